// File: rtl/ring_pattern_gen_if.sv
// Pixel request / result bundle between the scan controller, the ring
// generator and the panel shifter.
interface ring_pattern_gen_if #(
  parameter int COLS = 64,
  parameter int ROWS = 64
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          in_valid;
  logic [RW-2:0] line;
  logic [CW-1:0] column;

  logic          out_valid;
  logic [RW-2:0] out_line;
  logic [CW-1:0] out_column;
  logic          r1, g1, b1;
  logic          r2, g2, b2;

  modport master (
    output in_valid, line, column,
    input  out_valid, out_line, out_column, r1, g1, b1, r2, g2, b2
  );

  modport slave (
    input  in_valid, line, column,
    output out_valid, out_line, out_column, r1, g1, b1, r2, g2, b2
  );
endinterface

// File: rtl/ring_pattern_gen.sv
// Concentric-ring pixel generator: per-pixel squared-distance test against up
// to three animated rings (R/G/B), upper and lower panel halves in parallel.
module ring_pattern_gen #(
  parameter int COLS      = 64,
  parameter int ROWS      = 64,
  parameter int NUM_RINGS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ring_pattern_gen_if.slave        pix,
  input  logic                     frame_tick,
  input  logic                     anim_en,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_idx,
  input  logic [$clog2(COLS)-1:0]  cfg_cx,
  input  logic [$clog2(ROWS)-1:0]  cfg_cy,
  input  logic [$clog2(ROWS)-1:0]  cfg_r_in,
  input  logic [$clog2(ROWS)-1:0]  cfg_r_out,
  input  logic                     cfg_vx_neg,
  input  logic                     cfg_vy_neg
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int MW = (CW > RW) ? CW : RW;
  localparam int DW = 2 * MW + 2;
  localparam int NR = NUM_RINGS;
  localparam logic [MW:0] ONE_M = (MW+1)'(1);

  // Ring state
  logic [CW-1:0] r_cx    [NR];
  logic [RW-1:0] r_cy    [NR];
  logic [DW-1:0] r_rin2  [NR];
  logic [DW-1:0] r_rout2 [NR];
  logic [NR-1:0] r_dir_x;
  logic [NR-1:0] r_dir_y;

  // Pipeline registers
  logic          r_s0_valid;
  logic [RW-2:0] r_s0_line;
  logic [CW-1:0] r_s0_col;
  logic [MW:0]   r_s0_dx  [NR];
  logic [MW:0]   r_s0_dyt [NR];
  logic [MW:0]   r_s0_dyb [NR];
  logic          r_s1_valid;
  logic [RW-2:0] r_s1_line;
  logic [CW-1:0] r_s1_col;
  logic [DW-1:0] r_s1_dt  [NR];
  logic [DW-1:0] r_s1_db  [NR];

  logic [MW:0]   w_x, w_yt, w_yb;
  logic [MW:0]   w_dx  [NR];
  logic [MW:0]   w_dyt [NR];
  logic [MW:0]   w_dyb [NR];
  logic [2:0]    w_hit_top, w_hit_bot;

  function automatic logic [DW-1:0] sq_r(input logic [RW-1:0] r);
    logic [DW-1:0] e;
    e = DW'(r);
    return e * e;
  endfunction

  // Square of a two's-complement difference via its magnitude.
  function automatic logic [DW-1:0] sq_mag(input logic [MW:0] d);
    logic [MW:0]   m;
    logic [DW-1:0] e;
    if (d[MW]) m = ~d + ONE_M;
    else       m = d;
    e = DW'(m[MW-1:0]);
    return e * e;
  endfunction

  function automatic logic [CW:0] step_x(input logic dir, input logic [CW-1:0] p);
    logic [CW-1:0] pmax;
    pmax = '1;
    if (!dir) begin
      if (p == pmax) step_x = {1'b1, p - CW'(1)};
      else           step_x = {1'b0, p + CW'(1)};
    end else begin
      if (p == '0)   step_x = {1'b0, CW'(1)};
      else           step_x = {1'b1, p - CW'(1)};
    end
  endfunction

  function automatic logic [RW:0] step_y(input logic dir, input logic [RW-1:0] p);
    logic [RW-1:0] pmax;
    pmax = '1;
    if (!dir) begin
      if (p == pmax) step_y = {1'b1, p - RW'(1)};
      else           step_y = {1'b0, p + RW'(1)};
    end else begin
      if (p == '0)   step_y = {1'b0, RW'(1)};
      else           step_y = {1'b1, p - RW'(1)};
    end
  endfunction

  // Ring configuration and per-frame bounce; a write beats a tick on its ring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        r_cx[i]    <= CW'((i + 1) * COLS / 4);
        r_cy[i]    <= RW'(ROWS / 2);
        r_rin2[i]  <= DW'((ROWS / 4 - 2) * (ROWS / 4 - 2));
        r_rout2[i] <= DW'((ROWS / 4) * (ROWS / 4));
        r_dir_x[i] <= 1'b0;
        r_dir_y[i] <= ((i % 2) == 1);
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (cfg_we && (cfg_idx == 2'(i))) begin
          r_cx[i]    <= cfg_cx;
          r_cy[i]    <= cfg_cy;
          r_rin2[i]  <= sq_r(cfg_r_in);
          r_rout2[i] <= sq_r(cfg_r_out);
          r_dir_x[i] <= cfg_vx_neg;
          r_dir_y[i] <= cfg_vy_neg;
        end else if (frame_tick && anim_en) begin
          {r_dir_x[i], r_cx[i]} <= step_x(r_dir_x[i], r_cx[i]);
          {r_dir_y[i], r_cy[i]} <= step_y(r_dir_y[i], r_cy[i]);
        end else begin
          r_cx[i] <= r_cx[i];
        end
      end
    end
  end

  // Signed per-ring offsets; the lower-half row is the line with the MSB set.
  always_comb begin
    w_x  = (MW+1)'(pix.column);
    w_yt = (MW+1)'({1'b0, pix.line});
    w_yb = (MW+1)'({1'b1, pix.line});
    for (int i = 0; i < NR; i++) begin
      w_dx[i]  = w_x  - (MW+1)'(r_cx[i]);
      w_dyt[i] = w_yt - (MW+1)'(r_cy[i]);
      w_dyb[i] = w_yb - (MW+1)'(r_cy[i]);
    end
  end

  // S0: latch request and offsets against the current centres.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_line  <= '0;
      r_s0_col   <= '0;
      for (int i = 0; i < NR; i++) begin
        r_s0_dx[i]  <= '0;
        r_s0_dyt[i] <= '0;
        r_s0_dyb[i] <= '0;
      end
    end else begin
      r_s0_valid <= pix.in_valid;
      r_s0_line  <= pix.line;
      r_s0_col   <= pix.column;
      for (int i = 0; i < NR; i++) begin
        r_s0_dx[i]  <= w_dx[i];
        r_s0_dyt[i] <= w_dyt[i];
        r_s0_dyb[i] <= w_dyb[i];
      end
    end
  end

  // S1: squared distances for both halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_line  <= '0;
      r_s1_col   <= '0;
      for (int i = 0; i < NR; i++) begin
        r_s1_dt[i] <= '0;
        r_s1_db[i] <= '0;
      end
    end else begin
      r_s1_valid <= r_s0_valid;
      r_s1_line  <= r_s0_line;
      r_s1_col   <= r_s0_col;
      for (int i = 0; i < NR; i++) begin
        r_s1_dt[i] <= sq_mag(r_s0_dx[i]) + sq_mag(r_s0_dyt[i]);
        r_s1_db[i] <= sq_mag(r_s0_dx[i]) + sq_mag(r_s0_dyb[i]);
      end
    end
  end

  // Annulus membership; absent rings leave their channel dark.
  always_comb begin
    w_hit_top = 3'b000;
    w_hit_bot = 3'b000;
    for (int i = 0; i < NR; i++) begin
      w_hit_top[i] = (r_rin2[i] <= r_s1_dt[i]) && (r_s1_dt[i] <= r_rout2[i]);
      w_hit_bot[i] = (r_rin2[i] <= r_s1_db[i]) && (r_s1_db[i] <= r_rout2[i]);
    end
  end

  // S2: registered outputs, held between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.out_valid  <= 1'b0;
      pix.out_line   <= '0;
      pix.out_column <= '0;
      {pix.r1, pix.g1, pix.b1} <= 3'b000;
      {pix.r2, pix.g2, pix.b2} <= 3'b000;
    end else begin
      pix.out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        pix.out_line   <= r_s1_line;
        pix.out_column <= r_s1_col;
        {pix.r1, pix.g1, pix.b1} <= {w_hit_top[0], w_hit_top[1], w_hit_top[2]};
        {pix.r2, pix.g2, pix.b2} <= {w_hit_bot[0], w_hit_bot[1], w_hit_bot[2]};
      end else begin
        pix.out_line <= pix.out_line;
      end
    end
  end
endmodule

// File: tb/tb_ring_pattern_gen.sv
// Directed bench for ring_pattern_gen on a 64x64 panel: vector table plus
// config, bounce, collision, streaming and mid-pipeline reset sequences.
module tb_ring_pattern_gen;
  localparam int COLS = 64;
  localparam int ROWS = 64;

  logic       clk;
  logic       rst_n;
  logic       frame_tick, anim_en, cfg_we, cfg_vx_neg, cfg_vy_neg;
  logic [1:0] cfg_idx;
  logic [5:0] cfg_cx, cfg_cy, cfg_r_in, cfg_r_out;

  int n_cmp;
  int n_bad;

  ring_pattern_gen_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  ring_pattern_gen #(.COLS(COLS), .ROWS(ROWS), .NUM_RINGS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (bus),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_cx     (cfg_cx),
    .cfg_cy     (cfg_cy),
    .cfg_r_in   (cfg_r_in),
    .cfg_r_out  (cfg_r_out),
    .cfg_vx_neg (cfg_vx_neg),
    .cfg_vy_neg (cfg_vy_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ln;
    logic [5:0] col;
    logic [5:0] exp;   // {r1,g1,b1,r2,g2,b2}
  } vec_t;

  vec_t tbl [7];

  function automatic logic [5:0] pix_bits();
    return {bus.r1, bus.g1, bus.b1, bus.r2, bus.g2, bus.b2};
  endfunction

  // Golden annulus model for the reset-default rings.
  function automatic logic [5:0] gold_default(input int ln, input int col);
    logic [2:0] t, b;
    int cx, dt, db;
    t = 3'b000;
    b = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cx = (i + 1) * 16;
      dt = (col - cx) * (col - cx) + (ln - 32) * (ln - 32);
      db = (col - cx) * (col - cx) + (ln + 32 - 32) * (ln + 32 - 32);
      t[2-i] = (dt >= 196) && (dt <= 256);
      b[2-i] = (db >= 196) && (db <= 256);
    end
    return {t, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; ends at the negedge where the result is due.
  task automatic req_check(input string nm, input logic [4:0] ln, input logic [5:0] col,
                           input logic [5:0] exp);
    bus.in_valid = 1'b1;
    bus.line     = ln;
    bus.column   = col;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".rgb"}, 32'(pix_bits()), 32'(exp));
    chk({nm, ".coord"}, 32'({bus.out_line, bus.out_column}), 32'({ln, col}));
  endtask

  task automatic cfg(input int idx, input int cx, input int cy, input int rin, input int rout,
                     input logic vxn, input logic vyn, input logic tick);
    cfg_we     = 1'b1;
    cfg_idx    = 2'(idx);
    cfg_cx     = 6'(cx);
    cfg_cy     = 6'(cy);
    cfg_r_in   = 6'(rin);
    cfg_r_out  = 6'(rout);
    cfg_vx_neg = vxn;
    cfg_vy_neg = vyn;
    frame_tick = tick;
    anim_en    = tick;
    @(negedge clk);
    cfg_we     = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick(input logic en);
    frame_tick = 1'b1;
    anim_en    = en;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.line = '0;
    bus.column = '0;
    frame_tick = 1'b0; anim_en = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0;
    cfg_cx = '0; cfg_cy = '0; cfg_r_in = '0; cfg_r_out = '0;
    cfg_vx_neg = 1'b0; cfg_vy_neg = 1'b0;

    tbl[0] = '{ln: 5'd0,  col: 6'd32, exp: 6'b000101};
    tbl[1] = '{ln: 5'd0,  col: 6'd0,  exp: 6'b000100};
    tbl[2] = '{ln: 5'd17, col: 6'd16, exp: 6'b100000};
    tbl[3] = '{ln: 5'd18, col: 6'd32, exp: 6'b010000};
    tbl[4] = '{ln: 5'd2,  col: 6'd48, exp: 6'b000000};
    tbl[5] = '{ln: 5'd0,  col: 6'd63, exp: 6'b000001};
    tbl[6] = '{ln: 5'd16, col: 6'd48, exp: 6'b001001};

    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.rgb", 32'(pix_bits()), 32'd0);
    chk("rst.coord", 32'({bus.out_line, bus.out_column}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      req_check($sformatf("tbl%0d", i), tbl[i].ln, tbl[i].col, tbl[i].exp);

    // Single-pixel ring 1 at (10,10)
    cfg(1, 10, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    req_check("cfg.hit", 5'd10, 6'd10, 6'b010000);
    req_check("cfg.miss", 5'd10, 6'd11, 6'b000000);

    // Ring 0 at right edge moving right: must bounce back
    cfg(0, 63, 32, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    req_check("bounce1.hit", 5'd1, 6'd62, 6'b000100);
    req_check("bounce1.edge", 5'd1, 6'd63, 6'b000001);
    tick(1'b1);
    req_check("bounce2.hit", 5'd2, 6'd61, 6'b000100);
    req_check("bounce2.old", 5'd2, 6'd62, 6'b000000);
    tick(1'b0);
    req_check("noanim.hit", 5'd2, 6'd61, 6'b000100);

    // Config write and tick on ring 2 in the same cycle
    cfg(2, 5, 5, 0, 0, 1'b0, 1'b0, 1'b1);
    req_check("coll.hit", 5'd5, 6'd5, 6'b001000);
    req_check("coll.plus", 5'd5, 6'd6, 6'b000000);
    req_check("coll.minus", 5'd5, 6'd4, 6'b000000);

    // Reset with two requests in flight
    bus.in_valid = 1'b1; bus.line = 5'd0; bus.column = 6'd32;
    @(negedge clk);
    bus.column = 6'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.rgb", 32'(pix_bits()), 32'd0);
    chk("midrst.coord", 32'({bus.out_line, bus.out_column}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("midrst.stale%0d", n), 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back stream on line 5 against the default rings
    for (int n = 0; n < 69; n++) begin
      if (n >= 3 && n < 67) begin
        chk($sformatf("strm.valid%0d", n), 32'(bus.out_valid), 32'd1);
        chk($sformatf("strm.col%0d", n), 32'({bus.out_line, bus.out_column}),
            32'({5'd5, 6'(n - 3)}));
        chk($sformatf("strm.rgb%0d", n), 32'(pix_bits()), 32'(gold_default(5, n - 3)));
      end else begin
        chk($sformatf("strm.idle%0d", n), 32'(bus.out_valid), 32'd0);
      end
      if (n < 64) begin
        bus.in_valid = 1'b1;
        bus.line     = 5'd5;
        bus.column   = 6'(n);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
